multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instr_op_i, input, 7, opcode field of the instruction register (IR[6:0]).
REQ-004 SHALL have port mem_ready_i, input, 1, unified memory completes the current access this cycle.
REQ-005 SHALL have port PCWrite_o, output, 1, unconditional PC load.
REQ-006 SHALL have port Branch_o, output, 1, conditional PC load when ALU zero=1.
REQ-007 SHALL have port IorD_o, output, 1, memory address select: 0=PC, 1=ALUOut.
REQ-008 SHALL have ports MemRead_o and MemWrite_o, output, 1 each, memory strobes.
REQ-009 SHALL have port IRWrite_o, output, 1, instruction register load.
REQ-010 SHALL have port MemtoReg_o, output, 1, writeback select: 0=ALUOut, 1=MDR.
REQ-011 SHALL have port RegWrite_o, output, 1, register-file write enable.
REQ-012 SHALL have ports ALUSrcA_o (1: 0=PC, 1=rs1) and ALUSrcB_o (2: 00=rs2, 01=const 4, 10=imm).
REQ-013 SHALL have port ALU_op_o, output, 2: 00=add, 01=sub/compare, 10=R-type funct, 11=I-type funct.
REQ-014 SHALL have port PCSource_o, output, 1, PC next: 0=ALU result, 1=ALUOut.
REQ-015 SHALL have ports state_o (4, current state code) and illegal_o (1, sticky trap flag).

Function
REQ-016 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=0; IRWrite and PCWrite equal mem_ready_i; hold until mem_ready_i=1, then DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=10, ALU_op=00 (branch target into ALUOut); next state by instr_op_i: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH, any other->TRAP.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=00; next MEM_READ if opcode 0000011, else MEM_WRITE.
REQ-020 MEM_READ: MemRead=1, IorD=1; hold until mem_ready_i=1, then MEM_WB.
REQ-021 MEM_WB: RegWrite=1, MemtoReg=1; next FETCH.
REQ-022 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready_i=1, then FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_op=10; EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_op=11; both next ALU_WB.
REQ-024 ALU_WB: RegWrite=1, MemtoReg=0; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, Branch=1, PCSource=1; next FETCH.
REQ-026 TRAP: all strobes 0, illegal_o=1; remains in TRAP until reset.
REQ-027 Any output not listed for a state SHALL be 0 in that state.
REQ-028 Outputs SHALL be combinational from state (plus mem_ready_i in FETCH only); instr_op_i SHALL affect only next-state.
REQ-029 Zero-wait latency: R/I-type 4 cycles, load 5, store 4, beq 3; each mem_ready_i=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one cycle.
REQ-030 At most one of MemRead_o, MemWrite_o SHALL be 1; RegWrite_o never 1 together with MemWrite_o.
REQ-031 Unused state encodings SHALL transition to FETCH with all strobes 0.

Reset
REQ-032 rst_i=0 SHALL force state FETCH and clear illegal_o immediately, independent of clk_i.
REQ-033 While rst_i=0, PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o, Branch_o SHALL be 0; MemRead_o=1 permitted.
REQ-034 Reset asserted mid-instruction SHALL abandon it; no partial register or memory write after deassertion.

Structure
REQ-035 Shared package multicycle_pkg SHALL hold state encodings, opcode constants, ALU_op and ALUSrcB encodings.
REQ-036 No sub-module; state register, next-state logic and output decode live in multicycle_control.

Verification
REQ-037 add (op 0110011), mem_ready_i=1 -> states FETCH,DECODE,EXEC_R,ALU_WB,FETCH; RegWrite_o=1 in cycle 4 only.
REQ-038 ld (0000011), mem_ready_i low 2 cycles in MEM_READ -> 7 cycles total; MemtoReg_o=RegWrite_o=1 in MEM_WB only.
REQ-039 sd (0100011) -> MemWrite_o=1, IorD_o=1 one cycle in MEM_WRITE, RegWrite_o never 1.
REQ-040 beq (1100011) -> 3 cycles; Branch_o=1, ALU_op_o=01, PCSource_o=1 in BRANCH.
REQ-041 opcode 1111111 -> TRAP, illegal_o=1 held 10 cycles; rst_i pulse -> FETCH, illegal_o=0.
REQ-042 rst_i low asynchronously during MEM_WRITE -> MemWrite_o falls without clock edge; state_o=FETCH code.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// ALU/operand-select values, plus the opcode-to-state dispatch used in DECODE.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } stateT;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } aluOpT;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } srcBT;

  function automatic stateT decodeOp(input logic [6:0] op);
    stateT nxt;
    case (op)
      OP_RTYPE:           nxt = S_EXEC_R;
      OP_ITYPE:           nxt = S_EXEC_I;
      OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
      OP_BRANCH:          nxt = S_BRANCH;
      default:            nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: a single FSM sequences fetch, decode,
// execute, memory and writeback, and traps on unknown opcodes until reset.
//
// state       | meaning
// FETCH       | read instruction at PC, PC+4; waits on mem_ready_i
// DECODE      | dispatch on opcode, branch target into ALUOut
// MEM_ADDR    | rs1 + imm effective address
// MEM_READ    | load data access; waits on mem_ready_i
// MEM_WB      | MDR into register file
// MEM_WRITE   | store data access; waits on mem_ready_i
// EXEC_R      | register-register ALU operation
// EXEC_I      | register-immediate ALU operation
// ALU_WB      | ALUOut into register file
// BRANCH      | compare rs1/rs2, conditional PC load
// TRAP        | illegal opcode, parked until reset
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       Branch_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALU_op_o,
  output logic       PCSource_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  stateT stateQ, stateD;
  logic  illegalQ;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateQ   <= S_FETCH;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      illegalQ <= illegalQ | (stateD == S_TRAP);
    end
  end

  always_comb begin
    stateD = S_FETCH;
    case (stateQ)
      S_FETCH:     stateD = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:    stateD = decodeOp(instr_op_i);
      S_MEM_ADDR:  stateD = (instr_op_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  stateD = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    stateD = S_FETCH;
      S_MEM_WRITE: stateD = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    stateD = S_ALU_WB;
      S_EXEC_I:    stateD = S_ALU_WB;
      S_ALU_WB:    stateD = S_FETCH;
      S_BRANCH:    stateD = S_FETCH;
      S_TRAP:      stateD = S_TRAP;
      default:     stateD = S_FETCH;
    endcase
  end

  // rst_i gates the FETCH load strobes so nothing commits while reset is held.
  always_comb begin
    PCWrite_o  = 1'b0;
    Branch_o   = 1'b0;
    IorD_o     = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = SRCB_RS2;
    ALU_op_o   = ALU_ADD;
    PCSource_o = 1'b0;
    case (stateQ)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        IRWrite_o = mem_ready_i & rst_i;
        PCWrite_o = mem_ready_i & rst_i;
      end
      S_DECODE: ALUSrcB_o = SRCB_IMM;
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALU_op_o  = ALU_IFUNCT;
      end
      S_ALU_WB: RegWrite_o = 1'b1;
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALU_op_o   = ALU_SUB;
        Branch_o   = 1'b1;
        PCSource_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o   = stateQ;
  assign illegal_o = illegalQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench: the stimulus side expands each instruction into
// its expected cycle-by-cycle trace; a negedge monitor pops and compares.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic [6:0] instr_op_i = '0;
  logic       PCWrite_o, Branch_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegWrite_o, ALUSrcA_o, PCSource_o, illegal_o;
  logic [1:0] ALUSrcB_o, ALU_op_o;
  logic [3:0] state_o;

  multicycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .Branch_o(Branch_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o), .PCSource_o(PCSource_o),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pcWrite, branch, iorD, memRead, memWrite, irWrite, memtoReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp;
    logic       pcSource, illegal;
  } ctrlT;

  typedef struct packed {
    logic [3:0] st;
    ctrlT       c;
  } expT;

  expT sbQ[$];
  int  nChecks = 0;
  int  nPass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Control word each phase must present, straight from the per-state output table.
  function automatic ctrlT model(input stateT ph, input logic ready, input logic inReset);
    ctrlT c = '0;
    case (ph)
      S_FETCH: begin
        c.memRead = 1'b1; c.aluSrcB = 2'b01;
        c.irWrite = ready & ~inReset; c.pcWrite = ready & ~inReset;
      end
      S_DECODE:    c.aluSrcB = 2'b10;
      S_MEM_ADDR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      S_MEM_READ:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      S_MEM_WB:    begin c.regWrite = 1'b1; c.memtoReg = 1'b1; end
      S_MEM_WRITE: begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      S_EXEC_R:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      S_EXEC_I:    begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
      S_ALU_WB:    c.regWrite = 1'b1;
      S_BRANCH:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.branch = 1'b1; c.pcSource = 1'b1; end
      S_TRAP:      c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(input stateT ph, input logic ready, input logic [6:0] op, input logic rstLevel);
    expT e;
    @(posedge clk_i);
    #1;
    rst_i       = rstLevel;
    mem_ready_i = ready;
    instr_op_i  = op;
    e.st = ph;
    e.c  = model(ph, ready, ~rstLevel);
    sbQ.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic fetchPhase(input int fWait);
    repeat (fWait) cyc(S_FETCH, 1'b0, 7'($urandom), 1'b1);
    cyc(S_FETCH, 1'b1, 7'($urandom), 1'b1);
  endtask

  task automatic runInstr(input logic [6:0] op, input int fWait, input int mWait);
    fetchPhase(fWait);
    cyc(S_DECODE, rnd(), op, 1'b1);
    case (op)
      OP_RTYPE: begin cyc(S_EXEC_R, rnd(), op, 1'b1); cyc(S_ALU_WB, rnd(), op, 1'b1); end
      OP_ITYPE: begin cyc(S_EXEC_I, rnd(), op, 1'b1); cyc(S_ALU_WB, rnd(), op, 1'b1); end
      OP_LOAD: begin
        cyc(S_MEM_ADDR, rnd(), op, 1'b1);
        repeat (mWait) cyc(S_MEM_READ, 1'b0, op, 1'b1);
        cyc(S_MEM_READ, 1'b1, op, 1'b1);
        cyc(S_MEM_WB, rnd(), op, 1'b1);
      end
      OP_STORE: begin
        cyc(S_MEM_ADDR, rnd(), op, 1'b1);
        repeat (mWait) cyc(S_MEM_WRITE, 1'b0, op, 1'b1);
        cyc(S_MEM_WRITE, 1'b1, op, 1'b1);
      end
      OP_BRANCH: cyc(S_BRANCH, rnd(), op, 1'b1);
      default: begin
        repeat (10) cyc(S_TRAP, rnd(), 7'($urandom), 1'b1);
        cyc(S_FETCH, rnd(), op, 1'b0);
      end
    endcase
  endtask

  // Store abandoned by an asynchronous reset between clock edges.
  task automatic abortStore();
    expT e;
    fetchPhase(0);
    cyc(S_DECODE, 1'b1, OP_STORE, 1'b1);
    cyc(S_MEM_ADDR, 1'b1, OP_STORE, 1'b1);
    @(posedge clk_i);
    #1;
    mem_ready_i = 1'b0;
    #1;
    check("memwrite_before_rst", 32'(MemWrite_o), 32'd1);
    check("state_before_rst", 32'(state_o), 32'(S_MEM_WRITE));
    rst_i = 1'b0;
    #1;
    check("memwrite_async_rst", 32'(MemWrite_o), 32'd0);
    check("state_async_rst", 32'(state_o), 32'(S_FETCH));
    e.st = S_FETCH;
    e.c  = model(S_FETCH, 1'b0, 1'b1);
    sbQ.push_back(e);
  endtask

  always @(negedge clk_i) begin
    expT  e;
    ctrlT a;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      a = {PCWrite_o, Branch_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
           RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, PCSource_o, illegal_o};
      check("state", 32'(state_o), 32'(e.st));
      check("ctrl", 32'(a), 32'(e.c));
      check("rd_wr_exclusive", 32'(MemRead_o & MemWrite_o), 32'd0);
      check("regwr_memwr_exclusive", 32'(RegWrite_o & MemWrite_o), 32'd0);
    end
  end

  initial begin
    logic [6:0] ops[6];
    logic [6:0] badOps[4];
    ops[0] = OP_RTYPE; ops[1] = OP_ITYPE; ops[2] = OP_LOAD;
    ops[3] = OP_STORE; ops[4] = OP_BRANCH; ops[5] = 7'h7F;
    badOps[0] = 7'h7F; badOps[1] = 7'h00; badOps[2] = 7'b0110111; badOps[3] = 7'b1101111;

    rst_i = 1'b0;
    repeat (3) cyc(S_FETCH, rnd(), 7'($urandom), 1'b0);

    runInstr(OP_RTYPE, 0, 0);
    runInstr(OP_LOAD, 0, 2);
    runInstr(OP_STORE, 0, 0);
    runInstr(OP_BRANCH, 0, 0);
    runInstr(7'h7F, 0, 0);
    abortStore();
    runInstr(OP_ITYPE, 1, 0);

    for (int i = 0; i < 80; i++) begin
      int k;
      logic [6:0] op;
      k  = int'($urandom_range(0, 5));
      op = (k == 5) ? badOps[$urandom_range(0, 3)] : ops[k];
      runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
